// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative cache: controller state encoding
// and helpers that split a byte address into tag | index | word offset | byte.
package cache_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REFILL = 2'd1,
    S_WTHRU  = 2'd2
  } state_e;

  localparam int unsigned ADDR_W_DEF = 12;
  localparam int unsigned SETS_DEF   = 32;
  localparam int unsigned WORDS_DEF  = 4;

  // Byte offset is always 2 bits (word-aligned 32-bit accesses).
  localparam int unsigned OFF_LSB = 2;

  function automatic int unsigned idx_width(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned off_width(input int unsigned words);
    return $clog2(words);
  endfunction

  function automatic int unsigned tag_width(input int unsigned addr_w,
                                            input int unsigned sets,
                                            input int unsigned words);
    return addr_w - $clog2(sets) - $clog2(words) - OFF_LSB;
  endfunction

endpackage

// File: rtl/cache_way.sv
// One way of the cache: per-set valid bit, tag and block data with a
// combinational read/hit port and a synchronous word/line write port.
module cache_way #(
  parameter int unsigned TAG_W  = 5,
  parameter int unsigned IDX_W  = 5,
  parameter int unsigned OFF_W  = 2,
  parameter int unsigned DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [OFF_W-1:0]  rd_off,
  input  logic [TAG_W-1:0]  rd_tag,
  output logic              hit,
  output logic              valid,
  output logic [DATA_W-1:0] rd_word,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [OFF_W-1:0]  wr_off,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              set_line,
  input  logic [TAG_W-1:0]  set_tag,
  input  logic              inv_all
);

  localparam int unsigned SETS  = 1 << IDX_W;
  localparam int unsigned WORDS = 1 << OFF_W;

  logic [DATA_W-1:0] data_q [SETS*WORDS];
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   valid_d;

  always_comb begin
    valid_d = valid_q;
    if (inv_all) valid_d = '0;
    if (set_line) valid_d[wr_idx] = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) valid_q <= '0;
    else      valid_q <= valid_d;
  end

  // Data and tag arrays carry no reset; valid_q alone qualifies them.
  always_ff @(posedge CLK) begin
    if (wr_en)    data_q[{wr_idx, wr_off}] <= wr_data;
    if (set_line) tag_q[wr_idx] <= set_tag;
  end

  always_comb begin
    valid   = valid_q[rd_idx];
    hit     = valid && (tag_q[rd_idx] == rd_tag);
    rd_word = data_q[{rd_idx, rd_off}];
  end

endmodule

// File: rtl/cache_ctrl_assoc.sv
// 1- or 2-way set-associative write-through cache with LRU replacement,
// block refill over a ready handshake, CPU stall generation and hit/miss counters.
module cache_ctrl_assoc
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SETS   = SETS_DEF,
  parameter int unsigned WORDS  = WORDS_DEF,
  parameter int unsigned WAYS   = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              inv_all,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int unsigned IDX_W   = idx_width(SETS);
  localparam int unsigned OFF_W   = off_width(WORDS);
  localparam int unsigned TAG_W   = tag_width(ADDR_W, SETS, WORDS);
  localparam int unsigned IDX_LSB = OFF_LSB + OFF_W;
  localparam int unsigned TAG_LSB = IDX_LSB + IDX_W;

  state_e            state_q, state_d;
  logic [OFF_W-1:0]  word_cnt_q, word_cnt_d, word_nxt;
  logic              victim_q, victim_d, victim_sel;
  logic [SETS-1:0]   lru_q, lru_d;
  logic              mem_rd_req_q, mem_rd_req_d;
  logic              mem_wr_req_q, mem_wr_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

  logic [TAG_W-1:0]  a_tag, m_tag;
  logic [IDX_W-1:0]  a_idx, m_idx;
  logic [OFF_W-1:0]  a_off;

  logic [WAYS-1:0]   way_hit, way_valid, victim_oh, word_we, line_set;
  logic [DATA_W-1:0] way_word [WAYS];
  logic [DATA_W-1:0] hit_word;
  logic              hit, hit_way, rd_hit, inv_clr;
  logic [IDX_W-1:0]  wr_idx;
  logic [OFF_W-1:0]  wr_off;
  logic [DATA_W-1:0] wr_data;

  always_comb begin
    a_tag    = cpu_addr[ADDR_W-1:TAG_LSB];
    a_idx    = cpu_addr[TAG_LSB-1:IDX_LSB];
    a_off    = cpu_addr[IDX_LSB-1:OFF_LSB];
    m_tag    = mem_addr_q[ADDR_W-1:TAG_LSB];
    m_idx    = mem_addr_q[TAG_LSB-1:IDX_LSB];
    word_nxt = word_cnt_q + OFF_W'(1);
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cache_way #(
      .TAG_W (TAG_W),
      .IDX_W (IDX_W),
      .OFF_W (OFF_W),
      .DATA_W(DATA_W)
    ) u_way (
      .CLK     (CLK),
      .RST     (RST),
      .rd_idx  (a_idx),
      .rd_off  (a_off),
      .rd_tag  (a_tag),
      .hit     (way_hit[w]),
      .valid   (way_valid[w]),
      .rd_word (way_word[w]),
      .wr_en   (word_we[w]),
      .wr_idx  (wr_idx),
      .wr_off  (wr_off),
      .wr_data (wr_data),
      .set_line(line_set[w]),
      .set_tag (m_tag),
      .inv_all (inv_clr)
    );
  end

  always_comb begin
    hit      = |way_hit;
    hit_way  = (WAYS == 2) ? way_hit[WAYS-1] : 1'b0;
    hit_word = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (way_hit[w]) hit_word = hit_word | way_word[w];
      victim_oh[w] = (victim_q == 1'(w));
    end
  end

  // Fill an invalid way first (way0 before way1); otherwise replace the LRU way.
  always_comb begin
    victim_sel = 1'b0;
    if (!way_valid[0])                          victim_sel = 1'b0;
    else if ((WAYS == 2) && !way_valid[WAYS-1]) victim_sel = 1'b1;
    else if (WAYS == 2)                         victim_sel = lru_q[a_idx];
  end

  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    victim_d     = victim_q;
    lru_d        = lru_q;
    mem_rd_req_d = mem_rd_req_q;
    mem_wr_req_d = mem_wr_req_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    cpu_stall    = 1'b0;
    rd_hit       = 1'b0;
    inv_clr      = 1'b0;
    word_we      = '0;
    line_set     = '0;
    wr_idx       = a_idx;
    wr_off       = a_off;
    wr_data      = cpu_wdata;

    unique case (state_q)
      S_IDLE: begin
        if (cpu_wr) begin
          cpu_stall = 1'b1;
          if (hit) begin
            word_we          = way_hit;
            lru_d[a_idx]     = ~hit_way;
          end
          mem_addr_d   = cpu_addr;
          mem_wdata_d  = cpu_wdata;
          mem_wr_req_d = 1'b1;
          state_d      = S_WTHRU;
        end else if (cpu_rd) begin
          if (hit) begin
            rd_hit       = 1'b1;
            lru_d[a_idx] = ~hit_way;
            if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
          end else begin
            cpu_stall    = 1'b1;
            if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
            victim_d     = victim_sel;
            word_cnt_d   = '0;
            mem_addr_d   = {a_tag, a_idx, {OFF_W{1'b0}}, 2'b00};
            mem_rd_req_d = 1'b1;
            state_d      = S_REFILL;
          end
        end else if (inv_all) begin
          inv_clr = 1'b1;
        end
      end

      S_REFILL: begin
        cpu_stall = 1'b1;
        wr_idx    = m_idx;
        wr_off    = word_cnt_q;
        wr_data   = mem_rdata;
        if (mem_ready) begin
          word_we    = victim_oh;
          word_cnt_d = word_nxt;
          mem_addr_d = {m_tag, m_idx, word_nxt, 2'b00};
          if (&word_cnt_q) begin
            line_set     = victim_oh;
            lru_d[m_idx] = ~victim_q;
            mem_rd_req_d = 1'b0;
            state_d      = S_IDLE;
          end
        end
      end

      S_WTHRU: begin
        cpu_stall = ~mem_ready;
        if (mem_ready) begin
          mem_wr_req_d = 1'b0;
          state_d      = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= S_IDLE;
      word_cnt_q   <= '0;
      victim_q     <= 1'b0;
      lru_q        <= '0;
      mem_rd_req_q <= 1'b0;
      mem_wr_req_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      victim_q     <= victim_d;
      lru_q        <= lru_d;
      mem_rd_req_q <= mem_rd_req_d;
      mem_wr_req_q <= mem_wr_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  always_comb begin
    cpu_rdata  = rd_hit ? hit_word : '0;
    mem_rd_req = mem_rd_req_q;
    mem_wr_req = mem_wr_req_q;
    mem_addr   = mem_addr_q;
    mem_wdata  = mem_wdata_q;
    hit_cnt    = hit_cnt_q;
    miss_cnt   = miss_cnt_q;
  end

endmodule

// File: tb/tb_cache_ctrl_assoc.sv
// Directed bench for cache_ctrl_assoc: a default 2-way instance with a
// variable-latency memory model, plus a 1-way / 4-bit-counter instance.
module tb_cache_ctrl_assoc;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        cpu_rd = 1'b0, cpu_wr = 1'b0, inv_all = 1'b0;
  logic [11:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_rd_req, mem_wr_req;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [15:0] hit_cnt, miss_cnt;

  logic        s_cpu_rd = 1'b0, s_cpu_wr = 1'b0, s_inv_all = 1'b0;
  logic [11:0] s_cpu_addr = '0;
  logic [31:0] s_cpu_wdata = '0;
  logic [31:0] s_cpu_rdata;
  logic        s_cpu_stall;
  logic        s_mem_rd_req, s_mem_wr_req;
  logic [11:0] s_mem_addr;
  logic [31:0] s_mem_wdata;
  logic [31:0] s_mem_rdata;
  logic        s_mem_ready;
  logic [3:0]  s_hit_cnt, s_miss_cnt;

  int checks = 0;
  int errors = 0;
  int mem_lat = 1;
  int mem_cnt = 0;
  logic [11:0] rd_log[$];
  logic [11:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];

  cache_ctrl_assoc u_dut (
    .CLK(CLK), .RST(RST), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .inv_all(inv_all), .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  cache_ctrl_assoc #(.WAYS(1), .CNT_W(4)) u_small (
    .CLK(CLK), .RST(RST), .cpu_rd(s_cpu_rd), .cpu_wr(s_cpu_wr), .cpu_addr(s_cpu_addr),
    .cpu_wdata(s_cpu_wdata), .cpu_rdata(s_cpu_rdata), .cpu_stall(s_cpu_stall),
    .inv_all(s_inv_all), .mem_rd_req(s_mem_rd_req), .mem_wr_req(s_mem_wr_req),
    .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_rdata(s_mem_rdata),
    .mem_ready(s_mem_ready), .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt)
  );

  assign s_mem_ready = s_mem_rd_req | s_mem_wr_req;
  assign s_mem_rdata = {20'hA5A5A, s_mem_addr};

  always #5 CLK = ~CLK;

  // Memory model: ready after mem_lat cycles of a held request (0 = random 1..3).
  initial begin : mem_model
    forever begin
      @(posedge CLK);
      #2;
      mem_ready = 1'b0;
      if (!RST) begin
        mem_cnt = 0;
      end else if (mem_rd_req || mem_wr_req) begin
        if (mem_cnt == 0) mem_cnt = (mem_lat == 0) ? int'($urandom_range(3, 1)) : mem_lat;
        mem_cnt--;
        if (mem_cnt == 0) begin
          mem_ready = 1'b1;
          mem_rdata = {20'hA5A5A, mem_addr};
          if (mem_rd_req) begin
            rd_log.push_back(mem_addr);
          end else begin
            wr_addr_log.push_back(mem_addr);
            wr_data_log.push_back(mem_wdata);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input logic [11:0] a, input logic [31:0] exp, input string tag,
                         output int stalls);
    cpu_addr = a;
    cpu_rd   = 1'b1;
    stalls   = 0;
    @(negedge CLK);
    while (cpu_stall && stalls < 60) begin
      stalls++;
      @(negedge CLK);
    end
    check($sformatf("%s_unstall", tag), 32'(cpu_stall), 32'd0);
    check($sformatf("%s_rdata", tag), cpu_rdata, exp);
    @(posedge CLK);
    #1 cpu_rd = 1'b0;
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d, input string tag,
                          output int stalls);
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_wr    = 1'b1;
    stalls    = 0;
    @(negedge CLK);
    while (cpu_stall && stalls < 60) begin
      stalls++;
      @(negedge CLK);
    end
    check($sformatf("%s_unstall", tag), 32'(cpu_stall), 32'd0);
    @(posedge CLK);
    #1 cpu_wr = 1'b0;
  endtask

  task automatic s_read(input logic [11:0] a, input string tag, output int stalls);
    s_cpu_addr = a;
    s_cpu_rd   = 1'b1;
    stalls     = 0;
    @(negedge CLK);
    while (s_cpu_stall && stalls < 60) begin
      stalls++;
      @(negedge CLK);
    end
    check($sformatf("%s_rdata", tag), s_cpu_rdata, {20'hA5A5A, a});
    @(posedge CLK);
    #1 s_cpu_rd = 1'b0;
  endtask

  initial begin : stim
    int st;
    int base;
    int guard;

    // Reset values
    @(negedge CLK);
    @(negedge CLK);
    check("rst_mem_rd_req", 32'(mem_rd_req), 32'd0);
    check("rst_mem_wr_req", 32'(mem_wr_req), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_hit_cnt", 32'(hit_cnt), 32'd0);
    check("rst_miss_cnt", 32'(miss_cnt), 32'd0);
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    RST = 1'b1;
    @(posedge CLK);
    #1;

    // 1: cold read miss, refill of 0x400..0x40C, hit two cycles after last ready
    mem_lat = 1;
    do_read(12'h404, 32'hA5A5A404, "t1_rd404", st);
    check("t1_stalls", st, 32'd5);
    check("t1_nreads", rd_log.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t1_memaddr%0d", i), 32'(rd_log[i]), 32'h400 + 32'(4 * i));
    check("t1_hit_cnt", 32'(hit_cnt), 32'd1);
    check("t1_miss_cnt", 32'(miss_cnt), 32'd1);

    // 2: same-block hits without memory traffic
    do_read(12'h408, 32'hA5A5A408, "t2_rd408", st);
    check("t2_stall408", st, 32'd0);
    do_read(12'h40C, 32'hA5A5A40C, "t2_rd40c", st);
    check("t2_stall40c", st, 32'd0);
    check("t2_hit_cnt", 32'(hit_cnt), 32'd3);
    check("t2_nreads", rd_log.size(), 32'd4);

    // 3: LRU eviction in set 0 with random memory latency
    mem_lat = 0;
    do_read(12'h600, 32'hA5A5A600, "t3_rd600", st);
    check("t3_600_miss", 32'(st > 0), 32'd1);
    do_read(12'h400, 32'hA5A5A400, "t3_rd400", st);
    check("t3_400_hit", st, 32'd0);
    do_read(12'h000, 32'hA5A5A000, "t3_rd000", st);
    check("t3_000_miss", 32'(st > 0), 32'd1);
    do_read(12'h600, 32'hA5A5A600, "t3_rd600b", st);
    check("t3_600_evicted", 32'(st > 0), 32'd1);
    check("t3_hit_cnt", 32'(hit_cnt), 32'd7);
    check("t3_miss_cnt", 32'(miss_cnt), 32'd4);

    // 4: write-through hit and write miss without allocation
    mem_lat = 1;
    do_read(12'h404, 32'hA5A5A404, "t4_rd404", st);
    check("t4_refill_stalls", st, 32'd5);
    do_write(12'h404, 32'hAAAA1598, "t4_wr404", st);
    check("t4_wr_stalls", st, 32'd1);
    check("t4_nwrites", wr_addr_log.size(), 32'd1);
    check("t4_wr_addr", 32'(wr_addr_log[0]), 32'h404);
    check("t4_wr_data", wr_data_log[0], 32'hAAAA1598);
    check("t4_wr_req_low", 32'(mem_wr_req), 32'd0);
    do_read(12'h404, 32'hAAAA1598, "t4_rd404b", st);
    check("t4_rd404b_hit", st, 32'd0);
    base = rd_log.size();
    do_write(12'h800, 32'h12345678, "t4_wr800", st);
    check("t4_wr800_stalls", st, 32'd1);
    check("t4_wr800_addr", 32'(wr_addr_log[1]), 32'h800);
    check("t4_wr800_noalloc", rd_log.size(), 32'(base));
    do_read(12'h800, 32'hA5A5A800, "t4_rd800", st);
    check("t4_rd800_miss", st, 32'd5);
    check("t4_hit_cnt", 32'(hit_cnt), 32'd10);
    check("t4_miss_cnt", 32'(miss_cnt), 32'd6);

    // 5: reset during refill of 0xC00 after two words
    base     = rd_log.size();
    cpu_addr = 12'hC00;
    cpu_rd   = 1'b1;
    guard    = 0;
    while (rd_log.size() < base + 2 && guard < 50) begin
      @(posedge CLK);
      #3;
      guard++;
    end
    check("t5_refill_started", 32'(guard < 50), 32'd1);
    @(posedge CLK);
    #1;
    RST    = 1'b0;
    cpu_rd = 1'b0;
    #1;
    check("t5_mem_rd_req", 32'(mem_rd_req), 32'd0);
    check("t5_mem_addr", 32'(mem_addr), 32'd0);
    check("t5_mem_wdata", mem_wdata, 32'd0);
    check("t5_hit_cnt", 32'(hit_cnt), 32'd0);
    check("t5_miss_cnt", 32'(miss_cnt), 32'd0);
    check("t5_stall", 32'(cpu_stall), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    base = rd_log.size();
    do_read(12'hC00, 32'hA5A5AC00, "t5_rdC00", st);
    check("t5_rdC00_miss", st, 32'd5);
    check("t5_refill_addr", 32'(rd_log[base]), 32'hC00);

    // 6: invalidate-all, ignored when combined with a request
    do_read(12'h404, 32'hA5A5A404, "t6_rd404", st);
    do_read(12'h600, 32'hA5A5A600, "t6_rd600", st);
    inv_all = 1'b1;
    do_read(12'h404, 32'hA5A5A404, "t6_inv_with_rd", st);
    inv_all = 1'b0;
    check("t6_inv_ignored_404", st, 32'd0);
    do_read(12'h600, 32'hA5A5A600, "t6_rd600b", st);
    check("t6_inv_ignored_600", st, 32'd0);
    inv_all = 1'b1;
    @(posedge CLK);
    #1 inv_all = 1'b0;
    do_read(12'h404, 32'hA5A5A404, "t6_rd404_inv", st);
    check("t6_404_miss", st, 32'd5);
    do_read(12'h600, 32'hA5A5A600, "t6_rd600_inv", st);
    check("t6_600_miss", st, 32'd5);
    check("t6_hit_cnt", 32'(hit_cnt), 32'd7);
    check("t6_miss_cnt", 32'(miss_cnt), 32'd5);

    // 1-way build: conflict misses and 4-bit counter saturation
    s_read(12'h400, "s_rd400", st);
    check("s_400_miss", 32'(st > 0), 32'd1);
    s_read(12'h600, "s_rd600", st);
    check("s_600_miss", 32'(st > 0), 32'd1);
    s_read(12'h400, "s_rd400b", st);
    check("s_400b_miss", 32'(st > 0), 32'd1);
    check("s_miss_cnt", 32'(s_miss_cnt), 32'd3);
    check("s_hit_cnt3", 32'(s_hit_cnt), 32'd3);
    for (int i = 0; i < 11; i++) s_read(12'h404, "s_hit", st);
    check("s_hit_cnt14", 32'(s_hit_cnt), 32'd14);
    s_read(12'h408, "s_hit15", st);
    check("s_hit_cnt15", 32'(s_hit_cnt), 32'hF);
    for (int i = 0; i < 3; i++) s_read(12'h40C, "s_hit_sat", st);
    check("s_hit_cnt_sat", 32'(s_hit_cnt), 32'hF);
    check("s_miss_cnt_end", 32'(s_miss_cnt), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
